// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, FSM states,
// ALU operation codes and ALU/PC source selectors.
package ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BGTZ = 6'b000111;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    R_WB      = 4'd7,
    EXEC_I    = 4'd8,
    I_WB      = 4'd9,
    BRANCH    = 4'd10,
    JUMP      = 4'd11,
    HALT      = 4'd12
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/branch_eval.sv
// Branch condition evaluation from the ALU compare result (rs - rt).
module branch_eval
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                alu_res_msb,
  output logic                taken
);

  // bgtz: strictly positive means non-zero and sign bit clear
  always_comb begin
    taken = 1'b0;
    if (opcode == OPCODE_W'(OP_BEQ))
      taken = zero;
    else if (opcode == OPCODE_W'(OP_BNE))
      taken = ~zero;
    else if (opcode == OPCODE_W'(OP_BGTZ))
      taken = ~zero & ~alu_res_msb;
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle datapath controller: one FSM step per cycle, memory states
// stall on mem_ready, unsupported opcodes park the FSM in HALT until reset.
//
// state     | meaning
// FETCH     | read instruction at PC, PC <= PC + 4 when memory completes
// DECODE    | register read, branch target precompute into ALUOut
// MEM_ADDR  | effective address rs + imm
// MEM_READ  | load access, waits for mem_ready
// MEM_WB    | write MDR to rt
// MEM_WRITE | store access, waits for mem_ready
// EXEC_R    | ALU on rs, rt with funct
// R_WB      | write ALUOut to rd
// EXEC_I    | ALU rs + imm
// I_WB      | write ALUOut to rt
// BRANCH    | compare rs - rt, load branch target when taken
// JUMP      | load jump target
// HALT      | unsupported opcode, illegal held until reset
module multi_cycle_control
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int ALUOP_W     = 2,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                alu_res_msb,
  input  logic                mem_ready,
  output logic                pc_wr,
  output logic [1:0]          pc_src,
  output logic                ir_wr,
  output logic                i_or_d,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                mem_to_reg,
  output logic                reg_wr,
  output logic                reg_dst,
  output logic                ext_op,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                illegal,
  output logic [3:0]          state_dbg
);

  state_t r_state;
  state_t w_next;
  logic   w_taken;
  logic   w_mem_ready;

  assign w_mem_ready = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign state_dbg   = r_state;

  branch_eval #(.OPCODE_W(OPCODE_W)) u_branch_eval (
    .opcode      (opcode),
    .zero        (zero),
    .alu_res_msb (alu_res_msb),
    .taken       (w_taken)
  );

  // State register with synchronous reset back to FETCH
  always_ff @(posedge clk) begin
    if (reset)
      r_state <= FETCH;
    else
      r_state <= w_next;
  end

  // Next-state decode and per-state control outputs
  always_comb begin
    w_next     = r_state;
    pc_wr      = 1'b0;
    pc_src     = PCSRC_ALU;
    ir_wr      = 1'b0;
    i_or_d     = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_to_reg = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = 1'b0;
    ext_op     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = ALUOP_W'(ALU_ADD);
    illegal    = 1'b0;

    case (r_state)
      FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_wr     = w_mem_ready;
        pc_wr     = w_mem_ready;
        if (w_mem_ready) w_next = DECODE;
      end
      DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        ext_op    = 1'b1;
        if (opcode == OPCODE_W'(OP_LW) || opcode == OPCODE_W'(OP_SW))
          w_next = MEM_ADDR;
        else if (opcode == OPCODE_W'(OP_R))
          w_next = EXEC_R;
        else if (opcode == OPCODE_W'(OP_ADDI))
          w_next = EXEC_I;
        else if (opcode == OPCODE_W'(OP_BEQ) || opcode == OPCODE_W'(OP_BNE) ||
                 opcode == OPCODE_W'(OP_BGTZ))
          w_next = BRANCH;
        else if (opcode == OPCODE_W'(OP_J))
          w_next = JUMP;
        else
          w_next = HALT;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        ext_op    = 1'b1;
        w_next    = (opcode == OPCODE_W'(OP_LW)) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        i_or_d = 1'b1;
        mem_rd = 1'b1;
        if (w_mem_ready) w_next = MEM_WB;
      end
      MEM_WB: begin
        reg_wr     = 1'b1;
        mem_to_reg = 1'b1;
        w_next     = FETCH;
      end
      MEM_WRITE: begin
        i_or_d = 1'b1;
        mem_wr = 1'b1;
        if (w_mem_ready) w_next = FETCH;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_W'(ALU_FUNCT);
        w_next    = R_WB;
      end
      R_WB: begin
        reg_wr  = 1'b1;
        reg_dst = 1'b1;
        w_next  = FETCH;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        ext_op    = 1'b1;
        w_next    = I_WB;
      end
      I_WB: begin
        reg_wr = 1'b1;
        w_next = FETCH;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_W'(ALU_SUB);
        pc_src    = PCSRC_ALUOUT;
        pc_wr     = w_taken;
        w_next    = FETCH;
      end
      JUMP: begin
        pc_src = PCSRC_JUMP;
        pc_wr  = 1'b1;
        w_next = FETCH;
      end
      HALT: begin
        illegal = 1'b1;
      end
      default: w_next = FETCH;
    endcase

    // No architectural write or memory access may escape while reset is held
    if (reset) begin
      pc_wr  = 1'b0;
      ir_wr  = 1'b0;
      mem_rd = 1'b0;
      mem_wr = 1'b0;
      reg_wr = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: per-cycle vector table for all
// instruction classes, plus hand sequences for HALT and reset-in-store.
module tb_multi_cycle_control;

  localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1, S_MADDR = 4'd2,
                         S_MREAD = 4'd3,  S_MWB    = 4'd4, S_MWRITE = 4'd5,
                         S_EXR   = 4'd6,  S_RWB    = 4'd7, S_EXI    = 4'd8,
                         S_IWB   = 4'd9,  S_BR     = 4'd10, S_JMP   = 4'd11,
                         S_HALT  = 4'd12;

  localparam logic [5:0] O_R = 6'b000000, O_ADDI = 6'b001000, O_LW = 6'b100011,
                         O_SW = 6'b101011, O_BEQ = 6'b000100, O_BNE = 6'b000101,
                         O_BGTZ = 6'b000111, O_J = 6'b000010, O_BAD = 6'b111111;

  // {pc_wr,pc_src}_{ir_wr,i_or_d,mem_rd,mem_wr}_{mem_to_reg,reg_wr,reg_dst}
  // _{ext_op,alu_src_a,alu_src_b}_{alu_op}_{illegal}
  localparam logic [16:0] C_F1    = 17'b100_1010_000_0001_00_0;
  localparam logic [16:0] C_F0    = 17'b000_0010_000_0001_00_0;
  localparam logic [16:0] C_FRST  = 17'b000_0000_000_0001_00_0;
  localparam logic [16:0] C_DEC   = 17'b000_0000_000_1011_00_0;
  localparam logic [16:0] C_MADDR = 17'b000_0000_000_1110_00_0;
  localparam logic [16:0] C_MREAD = 17'b000_0110_000_0000_00_0;
  localparam logic [16:0] C_MWB   = 17'b000_0000_110_0000_00_0;
  localparam logic [16:0] C_MWR   = 17'b000_0101_000_0000_00_0;
  localparam logic [16:0] C_MWRST = 17'b000_0100_000_0000_00_0;
  localparam logic [16:0] C_EXR   = 17'b000_0000_000_0100_10_0;
  localparam logic [16:0] C_RWB   = 17'b000_0000_011_0000_00_0;
  localparam logic [16:0] C_EXI   = 17'b000_0000_000_1110_00_0;
  localparam logic [16:0] C_IWB   = 17'b000_0000_010_0000_00_0;
  localparam logic [16:0] C_BRT   = 17'b101_0000_000_0100_01_0;
  localparam logic [16:0] C_BRN   = 17'b001_0000_000_0100_01_0;
  localparam logic [16:0] C_JMP   = 17'b110_0000_000_0000_00_0;
  localparam logic [16:0] C_HALT  = 17'b000_0000_000_0000_00_1;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        zero;
    logic        msb;
    logic        rdy;
    logic [3:0]  st;
    logic [16:0] ctl;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero, alu_res_msb, mem_ready;
  logic       pc_wr, ir_wr, i_or_d, mem_rd, mem_wr, mem_to_reg, reg_wr, reg_dst;
  logic       ext_op, alu_src_a, illegal;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [3:0] state_dbg;
  logic [16:0] w_ctl;

  int errors = 0;
  int checks = 0;
  vec_t tbl[$];

  multi_cycle_control #(.OPCODE_W(6), .ALUOP_W(2), .MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .alu_res_msb(alu_res_msb), .mem_ready(mem_ready), .pc_wr(pc_wr),
    .pc_src(pc_src), .ir_wr(ir_wr), .i_or_d(i_or_d), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_to_reg(mem_to_reg), .reg_wr(reg_wr),
    .reg_dst(reg_dst), .ext_op(ext_op), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal(illegal),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  assign w_ctl = {pc_wr, pc_src, ir_wr, i_or_d, mem_rd, mem_wr, mem_to_reg,
                  reg_wr, reg_dst, ext_op, alu_src_a, alu_src_b, alu_op, illegal};

  task automatic add(input logic r, input logic [5:0] o, input logic z,
                     input logic m, input logic rd, input logic [3:0] s,
                     input logic [16:0] c);
    tbl.push_back('{r, o, z, m, rd, s, c});
  endtask

  // Drive at the falling edge, sample 1 time unit later, well before rising edge
  task automatic step(input logic r, input logic [5:0] o, input logic z,
                      input logic m, input logic rd);
    @(negedge clk);
    reset = r; opcode = o; zero = z; alu_res_msb = m; mem_ready = rd;
    #1;
  endtask

  task automatic check(input string name, input int idx,
                       input logic [3:0] exp_st, input logic [16:0] exp_ctl);
    checks++;
    if (state_dbg !== exp_st) begin
      errors++;
      $display("FAIL %s[%0d] state: got %0d expected %0d", name, idx, state_dbg, exp_st);
    end
    checks++;
    if (w_ctl !== exp_ctl) begin
      errors++;
      $display("FAIL %s[%0d] controls: got %b expected %b", name, idx, w_ctl, exp_ctl);
    end
  endtask

  initial begin
    // R-type
    add(1, O_R, 0, 0, 1, S_FETCH, C_FRST);
    add(0, O_R, 0, 0, 1, S_FETCH, C_F1);
    add(0, O_R, 0, 0, 1, S_DECODE, C_DEC);
    add(0, O_R, 0, 0, 1, S_EXR, C_EXR);
    add(0, O_R, 0, 0, 1, S_RWB, C_RWB);
    // addi
    add(0, O_ADDI, 0, 0, 1, S_FETCH, C_F1);
    add(0, O_ADDI, 0, 0, 1, S_DECODE, C_DEC);
    add(0, O_ADDI, 0, 0, 1, S_EXI, C_EXI);
    add(0, O_ADDI, 0, 0, 1, S_IWB, C_IWB);
    // lw with two wait cycles in MEM_READ: 7 cycles total
    add(0, O_LW, 0, 0, 1, S_FETCH, C_F1);
    add(0, O_LW, 0, 0, 1, S_DECODE, C_DEC);
    add(0, O_LW, 0, 0, 1, S_MADDR, C_MADDR);
    add(0, O_LW, 0, 0, 0, S_MREAD, C_MREAD);
    add(0, O_LW, 0, 0, 0, S_MREAD, C_MREAD);
    add(0, O_LW, 0, 0, 1, S_MREAD, C_MREAD);
    add(0, O_LW, 0, 0, 1, S_MWB, C_MWB);
    // sw with one wait cycle in FETCH
    add(0, O_SW, 0, 0, 0, S_FETCH, C_F0);
    add(0, O_SW, 0, 0, 1, S_FETCH, C_F1);
    add(0, O_SW, 0, 0, 1, S_DECODE, C_DEC);
    add(0, O_SW, 0, 0, 1, S_MADDR, C_MADDR);
    add(0, O_SW, 0, 0, 1, S_MWRITE, C_MWR);
    // beq zero=1 taken
    add(0, O_BEQ, 1, 0, 1, S_FETCH, C_F1);
    add(0, O_BEQ, 1, 0, 1, S_DECODE, C_DEC);
    add(0, O_BEQ, 1, 0, 1, S_BR, C_BRT);
    // bne zero=1 not taken
    add(0, O_BNE, 1, 0, 1, S_FETCH, C_F1);
    add(0, O_BNE, 1, 0, 1, S_DECODE, C_DEC);
    add(0, O_BNE, 1, 0, 1, S_BR, C_BRN);
    // bgtz positive taken
    add(0, O_BGTZ, 0, 0, 1, S_FETCH, C_F1);
    add(0, O_BGTZ, 0, 0, 1, S_DECODE, C_DEC);
    add(0, O_BGTZ, 0, 0, 1, S_BR, C_BRT);
    // bgtz negative not taken
    add(0, O_BGTZ, 0, 1, 1, S_FETCH, C_F1);
    add(0, O_BGTZ, 0, 1, 1, S_DECODE, C_DEC);
    add(0, O_BGTZ, 0, 1, 1, S_BR, C_BRN);
    // beq zero=0 not taken
    add(0, O_BEQ, 0, 0, 1, S_FETCH, C_F1);
    add(0, O_BEQ, 0, 0, 1, S_DECODE, C_DEC);
    add(0, O_BEQ, 0, 0, 1, S_BR, C_BRN);
    // j: jump in cycle 3, FETCH in cycle 4
    add(0, O_J, 0, 0, 1, S_FETCH, C_F1);
    add(0, O_J, 0, 0, 1, S_DECODE, C_DEC);
    add(0, O_J, 0, 0, 1, S_JMP, C_JMP);
    add(1, O_J, 0, 0, 1, S_FETCH, C_FRST);

    reset = 1'b1; opcode = O_R; zero = 1'b0; alu_res_msb = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].op, tbl[i].zero, tbl[i].msb, tbl[i].rdy);
      check("vec", i, tbl[i].st, tbl[i].ctl);
    end

    // Unsupported opcode: HALT, illegal held, cleared by reset
    step(0, O_BAD, 0, 0, 1); check("halt", 0, S_FETCH, C_F1);
    step(0, O_BAD, 0, 0, 1); check("halt", 1, S_DECODE, C_DEC);
    for (int k = 0; k < 10; k++) begin
      step(0, O_BAD, 0, 0, 1);
      check("halt_hold", k, S_HALT, C_HALT);
    end
    step(1, O_BAD, 0, 0, 1); check("halt_rst", 0, S_HALT, C_HALT);
    step(0, O_R, 0, 0, 1);   check("halt_rst", 1, S_FETCH, C_F1);

    // Reset while a store is stalled
    step(1, O_SW, 0, 0, 1); check("sw_rst", 0, S_DECODE, C_DEC);
    step(0, O_SW, 0, 0, 1); check("sw_rst", 1, S_FETCH, C_F1);
    step(0, O_SW, 0, 0, 1); check("sw_rst", 2, S_DECODE, C_DEC);
    step(0, O_SW, 0, 0, 1); check("sw_rst", 3, S_MADDR, C_MADDR);
    step(0, O_SW, 0, 0, 0); check("sw_rst", 4, S_MWRITE, C_MWR);
    step(0, O_SW, 0, 0, 0); check("sw_rst", 5, S_MWRITE, C_MWR);
    step(1, O_SW, 0, 0, 0); check("sw_rst", 6, S_MWRITE, C_MWRST);
    step(0, O_SW, 0, 0, 0); check("sw_rst", 7, S_FETCH, C_F0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 Parameter OPCODE_W, default 6, opcode field width.
REQ-002 Parameter ALUOP_W, default 2, ALU-control selector width.
REQ-003 Parameter MEM_WAIT_EN, default 1; 1 = honour mem_ready, 0 = treat mem_ready as constant 1.
REQ-004 Ports, one per line: name, direction, width, meaning.
  clk  in  1  single clock; all state on rising edge
  reset  in  1  synchronous, active-high reset
  opcode  in  OPCODE_W  instruction-register opcode field
  zero  in  1  ALU result == 0
  alu_res_msb  in  1  ALU result bit 31
  mem_ready  in  1  memory completes current access this cycle
  pc_wr  out  1  PC load strobe
  pc_src  out  2  0 ALU result, 1 ALUOut (branch target), 2 jump target
  ir_wr  out  1  instruction-register load strobe
  i_or_d  out  1  0 address from PC, 1 address from ALUOut
  mem_rd, mem_wr  out  1 each  memory strobes
  mem_to_reg  out  1  write-back data from MDR
  reg_wr, reg_dst  out  1 each  register-file write, rd (1) or rt (0) destination
  ext_op  out  1  sign-extend immediate
  alu_src_a  out  1  0 PC, 1 rs
  alu_src_b  out  2  0 rt, 1 constant 4, 2 ext imm, 3 ext imm << 2
  alu_op  out  ALUOP_W  00 add, 01 sub, 10 use funct
  illegal  out  1  sticky unsupported-opcode flag
  state_dbg  out  4  current state encoding

Function
REQ-005 Decoded opcodes: R 000000, addi 001000, lw 100011, sw 101011, beq 000100, bne 000101, bgtz 000111, j 000010.
REQ-006 States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP, HALT.
REQ-007 FETCH: i_or_d=0, mem_rd=1, alu_src_a=0, alu_src_b=1, alu_op=00, pc_src=0; ir_wr=pc_wr=mem_ready; advance to DECODE only when mem_ready=1, otherwise hold.
REQ-008 DECODE: alu_src_a=0, alu_src_b=3, ext_op=1, alu_op=00 (branch target precompute); next state: lw/sw->MEM_ADDR, R->EXEC_R, addi->EXEC_I, beq/bne/bgtz->BRANCH, j->JUMP, any other opcode->HALT.
REQ-009 MEM_ADDR: alu_src_a=1, alu_src_b=2, ext_op=1, alu_op=00; go to MEM_READ (lw) or MEM_WRITE (sw).
REQ-010 MEM_READ: i_or_d=1, mem_rd=1; hold until mem_ready, then MEM_WB. MEM_WB: reg_wr=1, reg_dst=0, mem_to_reg=1; then FETCH.
REQ-011 MEM_WRITE: i_or_d=1, mem_wr=1; hold until mem_ready, then FETCH.
REQ-012 EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=10; R_WB: reg_wr=1, reg_dst=1, mem_to_reg=0; then FETCH.
REQ-013 EXEC_I: alu_src_a=1, alu_src_b=2, ext_op=1, alu_op=00; I_WB: reg_wr=1, reg_dst=0; then FETCH.
REQ-014 BRANCH: alu_src_a=1, alu_src_b=0, alu_op=01, pc_src=1; pc_wr=taken, where beq taken=zero, bne taken=!zero, bgtz taken=!zero & !alu_res_msb; then FETCH.
REQ-015 JUMP: pc_src=2, pc_wr=1; then FETCH.
REQ-016 HALT: illegal=1, all strobes 0; remains until reset.
REQ-017 Any output not listed for a state SHALL be 0.
REQ-018 Zero-wait-state latency in cycles: R 4, addi 4, lw 5, sw 4, branch 3, j 3; each mem_ready=0 cycle adds exactly one cycle.
REQ-019 pc_wr, ir_wr, reg_wr and mem_wr SHALL never assert in the same cycle as reset.

Reset
REQ-020 reset=1 at a clock edge SHALL set state to FETCH and clear illegal, including mid-instruction and from HALT.
REQ-021 While reset=1, all strobes (pc_wr, ir_wr, mem_rd, mem_wr, reg_wr) SHALL be 0; the first fetch issues in the cycle after reset deasserts.

Structure
REQ-022 Opcode constants, state encoding, alu_op and alu_src_b codes SHALL live in shared package ctrl_pkg.
REQ-023 Branch-condition evaluation SHALL be sub-module branch_eval (opcode, zero, alu_res_msb -> taken).

Verification
REQ-024 R-type, mem_ready=1: state sequence FETCH, DECODE, EXEC_R, R_WB, FETCH; reg_wr=1 and reg_dst=1 only in R_WB.
REQ-025 lw with mem_ready=0 for 2 cycles in MEM_READ: 7-cycle instruction; reg_wr=1 and mem_to_reg=1 exactly once.
REQ-026 bne with zero=1 -> pc_wr=0 in BRANCH; bgtz with zero=0, alu_res_msb=0 -> pc_wr=1 and pc_src=1.
REQ-027 opcode 111111 in DECODE -> HALT, illegal=1 held for 10 cycles; reset -> illegal=0, state FETCH.
REQ-028 reset asserted in MEM_WRITE with mem_ready=0 -> mem_wr=0 during reset, FETCH on the following edge.
REQ-029 j -> pc_wr=1 and pc_src=2 in cycle 3, FETCH in cycle 4.
